// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the parametrised up/down counter
//
// Purpose : mode and direction constants plus a ceiling-log2 helper used to
//           size the optional prescaler phase register.
// Ports   : none (package).
package counter_pkg;

   // Boundary behaviour selected through the SATURATE parameter.
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Meaning of the updown input.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Ceiling log2, never less than 1 so a divide ratio of 1 still gets a
   // legal one-bit phase register.
   function automatic int clog2(input int value);
      int result;
      int rest;
      result = 0;
      rest   = value - 1;
      while (rest > 0) begin
         result = result + 1;
         rest   = rest >> 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/count_prescaler.sv
// rtl/count_prescaler.sv - enable prescaler producing one tick every PRE_DIV enabled cycles
//
// Purpose : counts enabled cycles 0..PRE_DIV-1 and raises tick on the enabled
//           cycle at the last phase, then returns to phase 0.
// Ports   : clk    - rising-edge clock
//           reset  - asynchronous active-low reset, phase -> 0
//           enable - advance the phase this cycle; phase holds when low
//           clear  - synchronous return to phase 0 (has priority over enable)
//           tick   - combinational, high on the enabled cycle at the last phase
module count_prescaler
   import counter_pkg::*;
#(
   parameter int PRE_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int             PW   = clog2(PRE_DIV);
   localparam logic [PW-1:0]  LAST = PW'(PRE_DIV - 1);

   logic [PW-1:0] phase;

   assign tick = enable & (phase == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (clear) begin
         phase <= '0;
      end else if (enable) begin
         if (phase == LAST) begin
            phase <= '0;
         end else begin
            phase <= phase + PW'(1);
         end
      end
   end

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with modulus, saturate, load and status
//
// Purpose : general counting/timing primitive. Counts 0..MAX_VAL up or down,
//           wrapping (SATURATE=0) or holding (SATURATE=1) at the boundaries.
//           Optional enable prescaler compiled in with COUNTER_PRESCALE_EN.
// Ports   : clk      - rising-edge clock
//           reset    - asynchronous active-low reset
//           enable   - count enable
//           updown   - 1 count up, 0 count down
//           load     - synchronous parallel load strobe (ignores enable)
//           load_val - value to load, clamped to MAX_VAL
//           count    - registered count
//           tc       - combinational terminal count for the current direction
//           wrap     - registered one-cycle pulse on a step taken at the boundary
module updown_counter_param
   import counter_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int MAX_VAL  = 31,
   parameter int SATURATE = 0,
   parameter int PRE_DIV  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             updown,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   // Elaboration-time parameter checks.
   if (WIDTH < 2) begin : g_bad_width
      $error("updown_counter_param: WIDTH must be >= 2");
   end
   if ((MAX_VAL < 1) || (MAX_VAL > ((1 << WIDTH) - 1))) begin : g_bad_max
      $error("updown_counter_param: MAX_VAL out of range for WIDTH");
   end
   if (PRE_DIV < 1) begin : g_bad_div
      $error("updown_counter_param: PRE_DIV must be >= 1");
   end

   localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAX_VAL);
   localparam logic             SAT_ON  = (SATURATE == MODE_SAT);

   logic             tick;
   logic             step;
   logic [WIDTH-1:0] next_count;
   logic             next_wrap;

`ifdef COUNTER_PRESCALE_EN
   count_prescaler #(
      .PRE_DIV (PRE_DIV)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (load),
      .tick   (tick)
   );
`else
   assign tick = 1'b1;
`endif

   assign step = enable & tick;

   // Terminal count depends on the direction being asked for right now, so a
   // direction change shows up on tc in the same cycle.
   assign tc = (updown == DIR_UP) ? (count == MAXV) : (count == '0);

   always_comb begin
      next_count = count;
      next_wrap  = 1'b0;
      if (load) begin
         next_count = (load_val > MAXV) ? MAXV : load_val;
      end else if (step) begin
         // Any step taken at the boundary pulses wrap, whether it wraps or
         // saturates.
         next_wrap = tc;
         if (updown == DIR_UP) begin
            if (count == MAXV) begin
               next_count = SAT_ON ? MAXV : '0;
            end else begin
               next_count = count + WIDTH'(1);
            end
         end else begin
            if (count == '0) begin
               next_count = SAT_ON ? '0 : MAXV;
            end else begin
               next_count = count - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= next_count;
         wrap  <= next_wrap;
      end
   end

endmodule
